// File: rtl/execute_stage.sv
// EX stage with the EX/MEM pipeline register: forwarding, ALU, branch/jump resolution.
// Define MULDIV_EN to add RV32M multiply (single cycle) and a multi-cycle radix-2 divider.
module execute_stage #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      funct3E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [2:0]      funct3M,
  output logic [4:0]      RdM
);

  logic [XLEN-1:0] src_a, src_b, write_data, alu_result;
  logic            lt_s, lt_u, branch_cond;

  // Select 11 falls back to the register value, same as 00.
  always_comb begin
    case (ForwardAE)
      2'b10:   src_a = ALUResultM;
      2'b01:   src_a = ResultW;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b10:   write_data = ALUResultM;
      2'b01:   write_data = ResultW;
      default: write_data = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data;

`ifdef MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  quot_reg, rem_reg, divisor_reg;
  logic             neg_q_reg, neg_r_reg, dzero_reg, rem_op_reg;
  logic             is_div, div_signed, a_neg, b_neg, div_start;
  logic [XLEN:0]    rem_shift, rem_diff;
  logic [XLEN-1:0]  q_final, r_final, div_result;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_full;

  // Sign/zero-extend per op; a single 2*XLEN product serves all four multiplies.
  assign mul_a    = (ALUControlE[1:0] == 2'b01 || ALUControlE[1:0] == 2'b10)
                  ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
  assign mul_b    = (ALUControlE[1:0] == 2'b01)
                  ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
  assign mul_full = mul_a * mul_b;

  assign is_div     = (ALUControlE[4:2] == 3'b101);
  assign div_signed = ~ALUControlE[0];
  assign a_neg      = div_signed & src_a[XLEN-1];
  assign b_neg      = div_signed & src_b[XLEN-1];
  assign div_start  = (state_reg == S_IDLE) && is_div;
  assign StallE     = div_start || (state_reg == S_RUN);

  assign rem_shift  = {rem_reg, quot_reg[XLEN-1]};
  assign rem_diff   = rem_shift - {1'b0, divisor_reg};
  assign q_final    = dzero_reg ? '1 : (neg_q_reg ? -quot_reg : quot_reg);
  assign r_final    = neg_r_reg ? -rem_reg : rem_reg;
  assign div_result = rem_op_reg ? r_final : q_final;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (is_div) state_next = S_RUN;
      S_RUN:   if (cnt_reg == CNT_W'(DIV_CYCLES - 1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      dzero_reg   <= 1'b0;
      rem_op_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (div_start) begin
        // Operands are captured now since forwarded sources may move during the stall.
        quot_reg    <= a_neg ? -src_a : src_a;
        rem_reg     <= '0;
        divisor_reg <= b_neg ? -src_b : src_b;
        neg_q_reg   <= a_neg ^ b_neg;
        neg_r_reg   <= a_neg;
        dzero_reg   <= (src_b == '0);
        rem_op_reg  <= ALUControlE[1];
        cnt_reg     <= '0;
      end else if (state_reg == S_RUN) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (!rem_diff[XLEN]) begin
          rem_reg  <= rem_diff[XLEN-1:0];
          quot_reg <= {quot_reg[XLEN-2:0], 1'b1};
        end else begin
          rem_reg  <= rem_shift[XLEN-1:0];
          quot_reg <= {quot_reg[XLEN-2:0], 1'b0};
        end
      end
    end
  end
`else
  assign StallE = 1'b0;
`endif

  assign lt_s = $signed(src_a) < $signed(src_b);
  assign lt_u = src_a < src_b;

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      5'b00000: alu_result = src_a + src_b;
      5'b00001: alu_result = src_a - src_b;
      5'b00010: alu_result = src_a & src_b;
      5'b00011: alu_result = src_a | src_b;
      5'b00100: alu_result = src_a ^ src_b;
      5'b00101: alu_result = src_a << src_b[4:0];
      5'b00110: alu_result = src_a >> src_b[4:0];
      5'b00111: alu_result = $signed(src_a) >>> src_b[4:0];
      5'b01000: alu_result = {{(XLEN-1){1'b0}}, lt_s};
      5'b01001: alu_result = {{(XLEN-1){1'b0}}, lt_u};
      5'b01010: alu_result = src_b;
`ifdef MULDIV_EN
      5'b10000: alu_result = mul_full[XLEN-1:0];
      5'b10001, 5'b10010, 5'b10011: alu_result = mul_full[2*XLEN-1:XLEN];
      5'b10100, 5'b10101, 5'b10110, 5'b10111: alu_result = div_result;
`endif
      default:  alu_result = '0;
    endcase
  end

  // Branches compare the two registers, never the immediate.
  always_comb begin
    branch_cond = 1'b0;
    case (funct3E)
      3'b000:  branch_cond = (src_a == write_data);
      3'b001:  branch_cond = (src_a != write_data);
      3'b100:  branch_cond = $signed(src_a) < $signed(write_data);
      3'b101:  branch_cond = $signed(src_a) >= $signed(write_data);
      3'b110:  branch_cond = src_a < write_data;
      3'b111:  branch_cond = src_a >= write_data;
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = (BranchE & branch_cond) | JumpE | JalrE;
  assign PCTargetE = JalrE ? ((src_a + ImmExtE) & ~XLEN'(1)) : (PCE + ImmExtE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      funct3M    <= '0;
      RdM        <= '0;
    end else if (!StallE) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= alu_result;
      WriteDataM <= write_data;
      PCPlus4M   <= PCPlus4E;
      funct3M    <= funct3E;
      RdM        <= RdE;
    end else begin
      // Bubble: suppress side effects while E is frozen.
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; MULDIV_EN adds divider scenarios.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [4:0]  ALUControlE, RdE;
  logic        ALUSrcE, BranchE, JumpE, JalrE, RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  funct3E;
  logic        PCSrcE, StallE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .JalrE(JalrE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .funct3E(funct3E), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .funct3M(funct3M), .RdM(RdM)
  );

  task automatic clear_inputs();
    RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; PCPlus4E = '0; ResultW = '0;
    ALUControlE = '0; RdE = '0; ALUSrcE = 0; BranchE = 0; JumpE = 0; JalrE = 0;
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = '0; ForwardAE = '0; ForwardBE = '0;
    funct3E = '0;
  endtask

  task automatic test_reset();
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, funct3M, RdM} !== '0) begin
      errors++; $display("FAIL reset_m_outputs: alu=%h wd=%h rw=%b", ALUResultM, WriteDataM, RegWriteM);
    end
    checks++;
    if (StallE !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallE); end
    $display("reset: M outputs and StallE checked");
  endtask

  task automatic test_add();
    clear_inputs();
    RD1E = 32'd5; RD2E = 32'hFFFFFFFD; RegWriteE = 1; RdE = 5'd3; ResultSrcE = 2'b01; funct3E = 3'b010;
    @(posedge clk); #1;
    checks++;
    if (ALUResultM !== 32'd2) begin errors++; $display("FAIL add_result: got %h want 00000002", ALUResultM); end
    checks++;
    if (WriteDataM !== 32'hFFFFFFFD) begin errors++; $display("FAIL add_wdata: got %h want fffffffd", WriteDataM); end
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM} !== {1'b1, 1'b0, 2'b01, 3'b010, 5'd3}) begin
      errors++; $display("FAIL add_ctrl: got rw=%b mw=%b rs=%b f3=%b rd=%0d", RegWriteM, MemWriteM, ResultSrcM, funct3M, RdM);
    end
    $display("add: 5 + 0xfffffffd -> %h", ALUResultM);
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    RD1E = 32'd7; RegWriteE = 1;
    @(posedge clk); #1;
    checks++;
    if (ALUResultM !== 32'd7) begin errors++; $display("FAIL fwd_setup: got %h want 00000007", ALUResultM); end
    ALUControlE = 5'b00001; ForwardAE = 2'b10; RD1E = 32'd100; RD2E = 32'd3;
    @(posedge clk); #1;
    checks++;
    if (ALUResultM !== 32'd4) begin errors++; $display("FAIL fwd_a_mem: got %h want 00000004", ALUResultM); end
    ALUControlE = 5'b00000; ForwardAE = 2'b00; ForwardBE = 2'b01; RD1E = 32'd1; RD2E = 32'd55; ResultW = 32'd9;
    @(posedge clk); #1;
    checks++;
    if (ALUResultM !== 32'd10) begin errors++; $display("FAIL fwd_b_wb: got %h want 0000000a", ALUResultM); end
    checks++;
    if (WriteDataM !== 32'd9) begin errors++; $display("FAIL fwd_b_wdata: got %h want 00000009", WriteDataM); end
    ForwardBE = 2'b11; RD2E = 32'd20;
    @(posedge clk); #1;
    checks++;
    if (ALUResultM !== 32'd21) begin errors++; $display("FAIL fwd_11_is_reg: got %h want 00000015", ALUResultM); end
    $display("back_to_back: forwarding sequence done, last=%h", ALUResultM);
  endtask

  task automatic test_alu_ops();
    logic [4:0]  op_t  [12] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                5'b00111, 5'b01000, 5'b01001, 5'b00000, 5'b01011, 5'b10000};
    logic [31:0] a_t   [12] = '{32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'd1, 32'h80000000,
                                32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd3};
    logic [31:0] b_t   [12] = '{32'd5, 32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00, 32'h24, 32'd4,
                                32'd4, 32'd1, 32'd1, 32'd1, 32'd6, 32'd5};
    logic [31:0] exp_t [12] = '{32'hFFFFFFFE, 32'hF000F000, 32'hFFFFF0F0, 32'h00FFFF00, 32'h10, 32'h08000000,
                                32'hF8000000, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
`ifdef MULDIV_EN
    exp_t[11] = 32'd15;
`endif
    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      ALUControlE = op_t[i]; RD1E = a_t[i]; RD2E = b_t[i];
      #1;
      checks++;
      if (StallE !== 1'b0) begin errors++; $display("FAIL alu_nostall[%0d]: got %b want 0", i, StallE); end
      @(posedge clk); #1;
      checks++;
      if (ALUResultM !== exp_t[i]) begin
        errors++; $display("FAIL alu_op[%0d] op=%b: got %h want %h", i, op_t[i], ALUResultM, exp_t[i]);
      end
      $display("alu op=%b a=%h b=%h -> %h", op_t[i], a_t[i], b_t[i], ALUResultM);
    end
    clear_inputs();
    ALUControlE = 5'b01010; ALUSrcE = 1; ImmExtE = 32'h12345000; RD2E = 32'hABCD;
    @(posedge clk); #1;
    checks++;
    if (ALUResultM !== 32'h12345000) begin errors++; $display("FAIL lui_pass: got %h want 12345000", ALUResultM); end
    checks++;
    if (WriteDataM !== 32'hABCD) begin errors++; $display("FAIL lui_wdata: got %h want 0000abcd", WriteDataM); end
    $display("lui: imm pass -> %h", ALUResultM);
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchE = 1; funct3E = 3'b100; RD1E = 32'hFFFFFFFF; RD2E = 32'd1; PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b want 1", PCSrcE); end
    checks++;
    if (PCTargetE !== 32'h120) begin errors++; $display("FAIL blt_target: got %h want 00000120", PCTargetE); end
    funct3E = 3'b110;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin errors++; $display("FAIL bltu_not_taken: got %b want 0", PCSrcE); end
    funct3E = 3'b000; ALUSrcE = 1; ImmExtE = 32'hFFFFFFFF;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin errors++; $display("FAIL beq_uses_rs2: got %b want 0", PCSrcE); end
    funct3E = 3'b010; ALUSrcE = 0; RD2E = 32'hFFFFFFFF;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin errors++; $display("FAIL f3_010_never: got %b want 0", PCSrcE); end
    BranchE = 0; JumpE = 1;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL jal_taken: got %b want 1", PCSrcE); end
    $display("branch: compare/jump cases done");
  endtask

  task automatic test_jalr();
    clear_inputs();
    JalrE = 1; RD1E = 32'h1001; ImmExtE = 32'd2; PCE = 32'h200; PCPlus4E = 32'h204; RegWriteE = 1;
    #1;
    checks++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1002) begin
      errors++; $display("FAIL jalr_target: got src=%b tgt=%h want 1/00001002", PCSrcE, PCTargetE);
    end
    @(posedge clk); #1;
    checks++;
    if (PCPlus4M !== 32'h204) begin errors++; $display("FAIL jalr_pc4m: got %h want 00000204", PCPlus4M); end
    $display("jalr: target=%h pcplus4m=%h", PCTargetE, PCPlus4M);
  endtask

  task automatic test_async_reset();
    clear_inputs();
    RegWriteE = 1; MemWriteE = 1; RD1E = 32'd1; RD2E = 32'd1; PCPlus4E = 32'h44; RdE = 5'd9;
    @(posedge clk); #1;
    checks++;
    if (RegWriteM !== 1'b1 || ALUResultM !== 32'd2) begin
      errors++; $display("FAIL areset_pre: got rw=%b alu=%h want 1/00000002", RegWriteM, ALUResultM);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, funct3M, RdM} !== '0) begin
      errors++; $display("FAIL areset_clear: got rw=%b alu=%h pc4=%h rd=%0d want all 0", RegWriteM, ALUResultM, PCPlus4M, RdM);
    end
    #2 rst = 1;
    $display("async_reset: M cleared mid-cycle");
  endtask

`ifdef MULDIV_EN
  task automatic test_div();
    logic [4:0]  op_t  [3] = '{5'b10100, 5'b10101, 5'b10110};
    logic [31:0] a_t   [3] = '{32'd7, 32'h1234, 32'h80000000};
    logic [31:0] b_t   [3] = '{32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF};
    logic [31:0] exp_t [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd0};
    int n;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      ALUControlE = op_t[i]; RD1E = a_t[i]; RD2E = b_t[i]; RegWriteE = 1; RdE = 5'd7;
      #1;
      checks++;
      if (StallE !== 1'b1) begin errors++; $display("FAIL div_stall_start[%0d]: got %b want 1", i, StallE); end
      n = 0;
      while (StallE === 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
        RD1E = 32'hDEAD0000;
        checks++;
        if (RegWriteM !== 1'b0) begin errors++; $display("FAIL div_bubble[%0d] cyc %0d: got rw=%b want 0", i, n, RegWriteM); end
      end
      checks++;
      if (n != 33) begin errors++; $display("FAIL div_stall_len[%0d]: got %0d want 33", i, n); end
      @(posedge clk); #1;
      checks++;
      if (ALUResultM !== exp_t[i] || RegWriteM !== 1'b1) begin
        errors++; $display("FAIL div_result[%0d]: got %h rw=%b want %h rw=1", i, ALUResultM, RegWriteM, exp_t[i]);
      end
      $display("div op=%b a=%h b=%h -> %h after %0d stall cycles", op_t[i], a_t[i], b_t[i], ALUResultM, n);
    end
  endtask
`endif

  initial begin
    rst = 0;
    clear_inputs();
    #2;
    test_reset();
    #1 rst = 1;
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_branch();
    test_jalr();
    test_async_reset();
`ifdef MULDIV_EN
    test_div();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage plus EX/MEM pipeline register.
- Consumes the ID/EX register outputs, applies forwarding, runs the ALU and resolves branches/jumps. Drives PCSrcE/PCTargetE back to fetch.
- Registers results into the M stage.
- Owns ALUResultM, which is fed back internally as the EX/MEM forwarding source.

Parameters:
XLEN, 32, datapath width
DIV_CYCLES, 32, iterations of the radix-2 divider (used only with MULDIV_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  32 each  ID/EX operands
ALUControlE  in  5  ALU operation
ALUSrcE, BranchE, JumpE, JalrE, RegWriteE, MemWriteE  in  1 each  ID/EX controls
ResultSrcE  in  2  writeback select
funct3E  in  3  branch compare / memory size
RdE  in  5  destination register
ForwardAE, ForwardBE  in  2 each  from hazard unit: 00 reg, 10 ALUResultM, 01 ResultW, 11 treated as 00
ResultW  in  32  writeback value
PCSrcE  out  1  redirect fetch
PCTargetE  out  32  redirect address
StallE  out  1  multi-cycle op in progress; hazard unit freezes F/D/E
RegWriteM, MemWriteM  out  1 each
ResultSrcM  out  2
ALUResultM, WriteDataM, PCPlus4M  out  32 each
funct3M  out  3
RdM  out  5

Behaviour:
- Reset (rst=0, async): every M-stage output = 0; StallE = 0; divider FSM to IDLE. No reset value applies to PCSrcE/PCTargetE; they are combinational.
- SrcAE = fwd(ForwardAE, RD1E). WriteDataE = fwd(ForwardBE, RD2E). SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU codes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA, 01000 SLT, 01001 SLTU, 01010 pass SrcBE (LUI). Any other code yields 0.
  - Shift amount = SrcBE[4:0].
  - Arithmetic wraps mod 2^32.
- Branch condition uses SrcAE vs WriteDataE (register compare, never the immediate):
  - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010/011 never taken.
- PCSrcE = (BranchE & cond) | JumpE | JalrE, combinational in the same cycle.
- PCTargetE = JalrE ? ((SrcAE + ImmExtE) & ~1) : (PCE + ImmExtE).
- EX/MEM register: on each posedge with StallE=0, captures all M outputs. ALUResultM = ALU result; WriteDataM = forwarded rs2. Latency 1 cycle.
- Bubble: while StallE=1, the M stage receives RegWriteM=0 and MemWriteM=0 each cycle. Other M fields hold.
- Single-cycle ops never assert StallE.

Optional Feature:
MULDIV_EN
- Defined: adds RV32M codes:
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU. These are single-cycle combinational, no stall.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU. These run a multi-cycle divider.
- Divider FSM is IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on a div code, latch SrcAE/SrcBE and the sign info, assert StallE, go to RUN. Operands are latched because ResultW may change during the stall.
  - RUN: DIV_CYCLES iterations, StallE=1.
  - DONE: StallE=0. The result is captured into ALUResultM with the instruction's controls on that edge; go to IDLE.
  - Total: DIV_CYCLES+1 stall cycles; result is in M on edge DIV_CYCLES+2.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- Reset mid-divide aborts to IDLE and clears StallE.
- Undefined: codes 1xxxx yield 0; StallE is tied 0; no divider logic is present.

Test Plan:
- ADD with ALUSrcE=0, RD1E=5, RD2E=0xFFFFFFFD, Fwd=00 -> after 1 clk ALUResultM=2, WriteDataM=0xFFFFFFFD.
- Back-to-back forwarding: ForwardAE=10 with ALUResultM=7, SUB with RD2E=3 -> ALUResultM=4; then ForwardBE=01 with ResultW=9, ADD with SrcA=1 -> 10.
- Branch: BranchE=1, funct3=100, SrcA=0xFFFFFFFF, B=1 -> PCSrcE=1, PCTargetE=PCE+ImmExtE. Same operands with funct3=110 -> PCSrcE=0.
- JALR: JalrE=1, SrcA=0x1001, Imm=2 -> PCTargetE=0x1002. PCPlus4M is registered next edge.
- Reset: assert rst=0 between clock edges with RegWriteM=1 -> all M outputs 0 immediately, before the next edge.
- MULDIV_EN: DIV 7/-2 -> StallE high 33 cycles, bubbles in M, then ALUResultM=0xFFFFFFFD. DIVU x/0 -> 0xFFFFFFFF. REM 0x80000000/-1 -> 0.
